// File: rtl/pr_bridge_pkg.sv
// Shared types and decode helpers for the multi-device CPU peripheral bridge.
package pr_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    localparam logic [1:0]  CTL_IRQ_MASK = 2'd0;
    localparam logic [1:0]  CTL_IRQ_PEND = 2'd1;
    localparam logic [1:0]  CTL_ERR_ADDR = 2'd2;
    localparam logic [31:0] CTL_WIN_MASK = 32'hFFFF_FFF0;

    // Address bits [1:0] never take part in decode.
    function automatic logic decode_hit(input logic [31:0] addr, input logic [31:0] base,
                                        input logic [31:0] mask);
        return (addr & mask & 32'hFFFF_FFFC) == (base & 32'hFFFF_FFFC);
    endfunction

endpackage

// File: rtl/pr_irq_ctrl.sv
// Interrupt controller: per-channel edge/level pending latch, mask, W1C clear, registered hw_int.
module pr_irq_ctrl
    import pr_bridge_pkg::*;
#(
    parameter int unsigned N_DEV    = 6,
    parameter logic [5:0]  IRQ_EDGE = 6'b000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_DEV-1:0] dev_irq,
    input  logic             mask_we,
    input  logic [N_DEV-1:0] mask_wd,
    input  logic [N_DEV-1:0] pend_clr,
    output logic [N_DEV-1:0] irq_mask,
    output logic [N_DEV-1:0] irq_pend,
    output logic [N_DEV-1:0] irq_hw
);

    logic [N_DEV-1:0] irq_q;
    logic [N_DEV-1:0] pend_d;

    // A new edge takes priority over a same-cycle W1C clear.
    always_comb begin
        pend_d = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (IRQ_EDGE[i]) begin
                pend_d[i] = (irq_pend[i] & ~pend_clr[i]) | (dev_irq[i] & ~irq_q[i]);
            end else begin
                pend_d[i] = dev_irq[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q    <= '0;
            irq_pend <= '0;
            irq_mask <= '0;
            irq_hw   <= '0;
        end else begin
            irq_q    <= dev_irq;
            irq_pend <= pend_d;
            irq_hw   <= irq_pend & irq_mask;
            if (mask_we) begin
                irq_mask <= mask_wd;
            end
        end
    end

endmodule

// File: rtl/pr_multi_bridge.sv
// CPU Pr* bus to N_DEV peripheral bridge with req/ack wait states, timeout bus error and an
// interrupt controller driving the CPU HWInt lines.
module pr_multi_bridge
    import pr_bridge_pkg::*;
#(
    parameter int unsigned         N_DEV    = 6,
    parameter logic [N_DEV*32-1:0] DEV_BASE = {N_DEV{32'h0}},
    parameter logic [N_DEV*32-1:0] DEV_MASK = {N_DEV{32'hFFFF_FFF0}},
    parameter logic [31:0]         CTL_BASE = 32'h0000_7F80,
    parameter int unsigned         TIMEOUT  = 15,
    parameter logic [5:0]          IRQ_EDGE = 6'b000000
) (
    input  logic                clk,
    input  logic                sys_rstn,
    input  logic                pr_req,
    input  logic                pr_we,
    input  logic [31:0]         pr_addr,
    input  logic [31:0]         pr_wd,
    input  logic [3:0]          pr_be,
    output logic [31:0]         pr_rd,
    output logic                pr_ack,
    output logic                pr_err,
    output logic [N_DEV-1:0]    dev_sel,
    output logic                dev_we,
    output logic [31:0]         dev_addr,
    output logic [31:0]         dev_wd,
    output logic [3:0]          dev_be,
    input  logic [N_DEV*32-1:0] dev_rd,
    input  logic [N_DEV-1:0]    dev_ready,
    input  logic [N_DEV-1:0]    dev_irq,
    output logic [5:0]          hw_int
);

    localparam int unsigned CNT_W = (TIMEOUT > 16) ? $clog2(TIMEOUT) : 4;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      err_addr_q;

    logic [N_DEV-1:0] hit_oh;
    logic             dev_hit;
    logic             ctl_hit;
    logic             sel_ready;
    logic [31:0]      sel_rd;
    logic [31:0]      ctl_rd;
    logic             ctl_wr;
    logic             mask_we;
    logic [N_DEV-1:0] pend_clr;
    logic [N_DEV-1:0] irq_mask;
    logic [N_DEV-1:0] irq_pend;
    logic [N_DEV-1:0] irq_hw;

    // Scan high to low so the lowest-index hit is the one that sticks.
    always_comb begin
        hit_oh  = '0;
        dev_hit = 1'b0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if (decode_hit(pr_addr, DEV_BASE[32*i +: 32], DEV_MASK[32*i +: 32])) begin
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
                dev_hit   = 1'b1;
            end
        end
        ctl_hit = decode_hit(pr_addr, CTL_BASE, CTL_WIN_MASK);
    end

    always_comb begin
        sel_rd = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (dev_sel[i]) begin
                sel_rd = sel_rd | dev_rd[32*i +: 32];
            end
        end
        sel_ready = |(dev_ready & dev_sel);
    end

    always_comb begin
        ctl_rd = '0;
        unique case (pr_addr[3:2])
            CTL_IRQ_MASK: ctl_rd[N_DEV-1:0] = irq_mask;
            CTL_IRQ_PEND: ctl_rd[N_DEV-1:0] = irq_pend;
            CTL_ERR_ADDR: ctl_rd = err_addr_q;
            default:      ctl_rd = '0;
        endcase
        ctl_wr   = (state_q == StIdle) && pr_req && pr_we && !dev_hit && ctl_hit;
        mask_we  = ctl_wr && (pr_addr[3:2] == CTL_IRQ_MASK) && pr_be[0];
        pend_clr = (ctl_wr && (pr_addr[3:2] == CTL_IRQ_PEND) && pr_be[0]) ?
                   pr_wd[N_DEV-1:0] : '0;
    end

    always_ff @(posedge clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            err_addr_q <= '0;
            pr_rd      <= '0;
            pr_ack     <= 1'b0;
            pr_err     <= 1'b0;
            dev_sel    <= '0;
            dev_we     <= 1'b0;
            dev_addr   <= '0;
            dev_wd     <= '0;
            dev_be     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    pr_ack <= 1'b0;
                    pr_err <= 1'b0;
                    pr_rd  <= '0;
                    if (pr_req) begin
                        dev_addr <= {pr_addr[31:2], 2'b00};
                        dev_wd   <= pr_wd;
                        dev_be   <= pr_be;
                        if (dev_hit) begin
                            dev_sel <= hit_oh;
                            dev_we  <= pr_we;
                            cnt_q   <= '0;
                            state_q <= StAccess;
                        end else if (ctl_hit) begin
                            pr_ack  <= 1'b1;
                            pr_rd   <= pr_we ? 32'h0 : ctl_rd;
                            state_q <= StResp;
                        end else begin
                            pr_ack     <= 1'b1;
                            pr_err     <= 1'b1;
                            err_addr_q <= {pr_addr[31:2], 2'b00};
                            state_q    <= StResp;
                        end
                    end
                end
                StAccess: begin
                    if (sel_ready) begin
                        pr_ack  <= 1'b1;
                        pr_rd   <= dev_we ? 32'h0 : sel_rd;
                        dev_sel <= '0;
                        dev_we  <= 1'b0;
                        state_q <= StResp;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        pr_ack     <= 1'b1;
                        pr_err     <= 1'b1;
                        err_addr_q <= dev_addr;
                        dev_sel    <= '0;
                        dev_we     <= 1'b0;
                        state_q    <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    pr_ack  <= 1'b0;
                    pr_err  <= 1'b0;
                    pr_rd   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    pr_irq_ctrl #(
        .N_DEV    (N_DEV),
        .IRQ_EDGE (IRQ_EDGE)
    ) u_irq (
        .clk      (clk),
        .rst_n    (sys_rstn),
        .dev_irq  (dev_irq),
        .mask_we  (mask_we),
        .mask_wd  (pr_wd[N_DEV-1:0]),
        .pend_clr (pend_clr),
        .irq_mask (irq_mask),
        .irq_pend (irq_pend),
        .irq_hw   (irq_hw)
    );

    always_comb begin
        hw_int             = '0;
        hw_int[N_DEV-1:0]  = irq_hw;
    end

endmodule

// File: tb/tb_pr_multi_bridge.sv
// Directed plus randomized bench for pr_multi_bridge against a transaction-level reference model.
module tb_pr_multi_bridge;

    localparam int          N    = 6;
    localparam int          TO   = 15;
    localparam logic [31:0] CTL  = 32'h0000_7F80;
    localparam logic [5:0]  EDGE = 6'b011010;
    // ch5 window (0x1400-0x14FF) overlaps ch4 (0x1400-0x140F); ch4 must win there.
    localparam logic [N*32-1:0] BASES = {32'h0000_1400, 32'h0000_1400, 32'h0000_1300,
                                         32'h0000_1200, 32'h0000_1100, 32'h0000_1000};
    localparam logic [N*32-1:0] MASKS = {32'hFFFF_FF00, {5{32'hFFFF_FFF0}}};

    logic            clk = 1'b0;
    logic            sys_rstn = 1'b0;
    logic            pr_req = 1'b0;
    logic            pr_we = 1'b0;
    logic [31:0]     pr_addr = '0;
    logic [31:0]     pr_wd = '0;
    logic [3:0]      pr_be = '0;
    logic [31:0]     pr_rd;
    logic            pr_ack;
    logic            pr_err;
    logic [N-1:0]    dev_sel;
    logic            dev_we;
    logic [31:0]     dev_addr;
    logic [31:0]     dev_wd;
    logic [3:0]      dev_be;
    logic [N*32-1:0] dev_rd;
    logic [N-1:0]    dev_ready;
    logic [N-1:0]    dev_irq = '0;
    logic [5:0]      hw_int;

    int          vectors = 0;
    int          miscompares = 0;
    int          lat [N];
    logic [31:0] rd_data [N];
    logic        all_ready = 1'b0;
    int          acc_cyc = 0;
    logic [5:0]  mask_m = '0;
    logic [5:0]  pend_m = '0;
    logic [31:0] err_m = '0;

    pr_multi_bridge #(
        .N_DEV    (N),
        .DEV_BASE (BASES),
        .DEV_MASK (MASKS),
        .CTL_BASE (CTL),
        .TIMEOUT  (TO),
        .IRQ_EDGE (EDGE)
    ) dut (
        .clk       (clk),
        .sys_rstn  (sys_rstn),
        .pr_req    (pr_req),
        .pr_we     (pr_we),
        .pr_addr   (pr_addr),
        .pr_wd     (pr_wd),
        .pr_be     (pr_be),
        .pr_rd     (pr_rd),
        .pr_ack    (pr_ack),
        .pr_err    (pr_err),
        .dev_sel   (dev_sel),
        .dev_we    (dev_we),
        .dev_addr  (dev_addr),
        .dev_wd    (dev_wd),
        .dev_be    (dev_be),
        .dev_rd    (dev_rd),
        .dev_ready (dev_ready),
        .dev_irq   (dev_irq),
        .hw_int    (hw_int)
    );

    always #5 clk = ~clk;

    // Device model: selected channel answers after lat[i] wait cycles.
    always @(posedge clk) acc_cyc <= (dev_sel != '0) ? acc_cyc + 1 : 0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            dev_ready[i]        = all_ready | (dev_sel[i] && (acc_cyc >= lat[i]));
            dev_rd[32*i +: 32]  = rd_data[i];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_chan(input logic [31:0] a);
        for (int i = 0; i < N; i++) begin
            if ((a & MASKS[32*i +: 32] & 32'hFFFF_FFFC) == (BASES[32*i +: 32] & 32'hFFFF_FFFC))
                return i;
        end
        return -1;
    endfunction

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rd, output logic err,
                          output int lat_o, output int selc, output logic [5:0] sel_s,
                          output logic we_s);
        @(negedge clk);
        pr_req = 1'b1; pr_we = we; pr_addr = addr; pr_wd = wd; pr_be = be;
        @(negedge clk);
        pr_req = 1'b0;
        lat_o = -1; selc = 0; sel_s = '0; we_s = 1'b0; rd = '0; err = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (pr_ack) begin
                lat_o = n; rd = pr_rd; err = pr_err;
                break;
            end
            if (dev_sel != '0) begin
                selc++; sel_s = dev_sel; we_s = dev_we;
            end
            @(negedge clk);
        end
    endtask

    task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be);
        int ch, elat, ecyc, lat_o, selc;
        logic is_ctl, eerr, err, we_s;
        logic [31:0] erd, rd;
        logic [5:0] sel_s;
        ch = ref_chan(addr);
        is_ctl = ((addr & 32'hFFFF_FFF0) == CTL);
        erd = '0; eerr = 1'b0;
        if (ch >= 0) begin
            if (all_ready || lat[ch] <= TO - 1) begin
                elat = (all_ready ? 0 : lat[ch]) + 2;
                erd  = we ? 32'h0 : rd_data[ch];
            end else begin
                elat = TO + 1; eerr = 1'b1; err_m = {addr[31:2], 2'b00};
            end
            ecyc = elat - 1;
        end else if (is_ctl) begin
            elat = 1; ecyc = 0;
            case (addr[3:2])
                2'd0: erd = {26'h0, mask_m};
                2'd1: erd = {26'h0, pend_m};
                2'd2: erd = err_m;
                default: erd = '0;
            endcase
            if (we && be[0] && addr[3:2] == 2'd0) mask_m = wd[5:0];
            if (we && be[0] && addr[3:2] == 2'd1) pend_m = pend_m & ~(wd[5:0] & EDGE);
        end else begin
            elat = 1; ecyc = 0; eerr = 1'b1; err_m = {addr[31:2], 2'b00};
        end
        access(we, addr, wd, be, rd, err, lat_o, selc, sel_s, we_s);
        chk({tag, "_lat"}, lat_o, elat);
        chk({tag, "_err"}, 32'(err), 32'(eerr));
        if (!(is_ctl && we)) chk({tag, "_rd"}, rd, erd);
        chk({tag, "_selcyc"}, selc, ecyc);
        if (ch >= 0) begin
            chk({tag, "_sel"}, 32'(sel_s), 32'(6'b1 << ch));
            chk({tag, "_we"}, 32'(we_s), 32'(we));
        end
    endtask

    initial begin
        int ch, kind, r, acks;
        logic [31:0] addr;
        for (int i = 0; i < N; i++) begin
            lat[i] = 0; rd_data[i] = 32'hA000_0000 + i;
        end

        #1;
        chk("rst_ack", 32'(pr_ack), 0);
        chk("rst_sel", 32'(dev_sel), 0);
        chk("rst_hw", 32'(hw_int), 0);
        chk("rst_rd", pr_rd, 0);
        repeat (2) @(negedge clk);
        sys_rstn = 1'b1;

        all_ready = 1'b1;
        rd_data[2] = 32'hCAFE_0002;
        xfer("t1_rd_ch2", 1'b0, 32'h0000_1200, 32'h0, 4'h0);
        all_ready = 1'b0;

        lat[0] = 3;
        xfer("t2_wr_ch0", 1'b1, 32'h0000_1004, 32'h1234_5678, 4'hF);
        @(negedge clk);
        chk("t2_single_ack", 32'(pr_ack), 0);

        lat[1] = 1000;
        xfer("t3_timeout", 1'b0, 32'h0000_1108, 32'h0, 4'h0);
        xfer("t3_erraddr", 1'b0, CTL + 32'h8, 32'h0, 4'h0);

        xfer("t4_unmapped", 1'b0, 32'hDEAD_0000, 32'h0, 4'h0);
        xfer("t4_erraddr", 1'b0, CTL + 32'h8, 32'h0, 4'h0);

        lat[4] = 1; lat[5] = 2; rd_data[4] = 32'h4444_0004; rd_data[5] = 32'h5555_0005;
        xfer("ovl_ch4", 1'b0, 32'h0000_1404, 32'h0, 4'h0);
        xfer("ovl_ch5", 1'b0, 32'h0000_1480, 32'h0, 4'h0);
        lat[0] = 14;
        xfer("ready_last", 1'b0, 32'h0000_1000, 32'h0, 4'h0);
        xfer("mask_be0", 1'b1, CTL, 32'h3F, 4'hE);
        xfer("mask_rb", 1'b0, CTL, 32'h0, 4'h0);
        xfer("rsvd_rd", 1'b0, CTL + 32'hC, 32'h0, 4'h0);

        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 5);
            if (kind <= 2) begin
                ch = $urandom_range(0, N - 1);
                r = $urandom_range(0, 9);
                lat[ch] = (r == 0) ? 14 : (r == 1) ? 15 : $urandom_range(0, 4);
                rd_data[ch] = $urandom;
                addr = BASES[32*ch +: 32] + 32'($urandom_range(0, 15));
            end else if (kind <= 4) begin
                addr = CTL + 32'($urandom_range(0, 15));
            end else begin
                addr = 32'hDEAD_0000 + 32'($urandom_range(0, 255));
            end
            xfer("rand", 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
        end

        // Edge-latched interrupt on channel 3.
        xfer("irq_mask", 1'b1, CTL, 32'h08, 4'hF);
        @(negedge clk); dev_irq[3] = 1'b1;
        @(negedge clk); dev_irq[3] = 1'b0;
        @(negedge clk);
        chk("irq_edge_set", 32'(hw_int), 32'h08);
        repeat (3) @(negedge clk);
        chk("irq_edge_hold", 32'(hw_int), 32'h08);
        pend_m = 6'h08;
        xfer("irq_pend_rd", 1'b0, CTL + 32'h4, 32'h0, 4'h0);
        @(negedge clk);
        dev_irq[3] = 1'b1;
        pr_req = 1'b1; pr_we = 1'b1; pr_addr = CTL + 32'h4; pr_wd = 32'h8; pr_be = 4'hF;
        @(negedge clk); pr_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("irq_set_beats_clr", 32'(hw_int), 32'h08);
        xfer("irq_clr", 1'b1, CTL + 32'h4, 32'h8, 4'hF);
        @(negedge clk);
        chk("irq_cleared", 32'(hw_int), 32'h00);
        dev_irq[3] = 1'b0;

        // Level interrupt on channel 0 mirrors the input and ignores W1C.
        xfer("irq_mask2", 1'b1, CTL, 32'h09, 4'hF);
        dev_irq[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("lvl_set", 32'(hw_int), 32'h01);
        pend_m = 6'h01;
        xfer("lvl_w1c", 1'b1, CTL + 32'h4, 32'h1, 4'hF);
        repeat (2) @(negedge clk);
        chk("lvl_w1c_noeff", 32'(hw_int), 32'h01);
        xfer("lvl_pend_rd", 1'b0, CTL + 32'h4, 32'h0, 4'h0);
        dev_irq[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("lvl_drop", 32'(hw_int), 32'h00);
        pend_m = '0;

        // Reset in the middle of a never-ready access.
        lat[1] = 1000;
        @(negedge clk);
        pr_req = 1'b1; pr_we = 1'b1; pr_addr = 32'h0000_1100; pr_wd = 32'h5A5A; pr_be = 4'hF;
        @(negedge clk); pr_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_sel_before", 32'(dev_sel), 32'h02);
        #2 sys_rstn = 1'b0;
        #1;
        chk("rst_mid_sel", 32'(dev_sel), 0);
        chk("rst_mid_we", 32'(dev_we), 0);
        acks = 0;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            if (n == 2) sys_rstn = 1'b1;
            if (pr_ack) acks++;
        end
        chk("rst_no_ack", acks, 0);
        chk("rst_hw_after", 32'(hw_int), 0);
        mask_m = '0; pend_m = '0; err_m = '0;
        xfer("rst_mask", 1'b0, CTL, 32'h0, 4'h0);
        xfer("rst_erraddr", 1'b0, CTL + 32'h8, 32'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
